ctrl_decode_pipe: RTL

//  Registered ID-stage decoder: decodes RV32I (+ optional RV32M) instructions into one packed ctrl_t bundle.

---
 rtl/ctrl_pkg.sv | 101 ++++++++++
 rtl/ctrl_decode_core.sv | 168 ++++++++++++++++
 rtl/ctrl_decode_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the ID-stage decoder.
//   ctrl_t      packed control bundle produced per instruction
//   enums       br_type_e, op_a_sel_e, wb_sel_e, mem_size_e
//   constants   ALU operation codes, RV32 major opcodes, BUBBLE (all-zero bundle)
//   base_alu_op helper mapping funct3 (+ alternate bit) to an ALU operation
// Build option: CTRL_ILLEGAL_TRAP_EN (see ctrl_decode_core / ctrl_decode_pipe).
package ctrl_pkg;

    localparam int CTRL_ALU_OP_W = 5;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_JAL  = 3'd5,
        BR_JALR = 3'd6
    } br_type_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    // Every enum's zero value is the inactive choice, so '0 is a bubble.
    typedef struct packed {
        logic                     illegal;
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic                     op_b_imm;
        op_a_sel_e                op_a_sel;
        logic                     rd_wren;
        logic                     mem_rden;
        logic                     mem_wren;
        mem_size_e                mem_size;
        logic                     mem_unsigned;
        br_type_e                 br_type;
        logic                     br_unsigned;
        wb_sel_e                  wb_sel;
        logic                     uses_rs1;
        logic                     uses_rs2;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    localparam logic [CTRL_ALU_OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SLT  = 5'd2;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SLTU = 5'd3;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OR   = 5'd5;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_AND  = 5'd6;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SLL  = 5'd7;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SRL  = 5'd8;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SRA  = 5'd9;
    // M-extension ops are ALU_MUL + funct3 (MUL..REMU = 16..23).
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_MUL  = 5'd16;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // funct3 -> ALU op for OP / OP-IMM; alt selects SUB (000) or SRA (101).
    function automatic logic [CTRL_ALU_OP_W-1:0] base_alu_op(input logic [2:0] funct3,
                                                             input logic       alt);
        logic [CTRL_ALU_OP_W-1:0] op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode_core.sv
// ctrl_decode_core: purely combinational RV32I (+ optional RV32M) decoder.
//   instr  in   32           raw instruction
//   ctrl   out  ctrl_t       decoded bundle; BUBBLE for unrecognised encodings
// Parameters: M_EXT (1 = accept MUL..REMU), ALU_OP_W (internal alu_op width, >=5).
// Build option CTRL_ILLEGAL_TRAP_EN: when defined, ctrl.illegal flags unrecognised
// encodings; otherwise ctrl.illegal is always 0.
module ctrl_decode_core
    import ctrl_pkg::*;
#(
    parameter int M_EXT    = 0,
    parameter int ALU_OP_W = 5
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                legal;
    logic                writes_rd;
    logic                reads_rs1;
    logic                reads_rs2;
    logic [ALU_OP_W-1:0] alu_op;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    always_comb begin
        ctrl      = BUBBLE;
        legal     = 1'b0;
        writes_rd = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        alu_op    = ALU_OP_W'(ALU_ADD);

        case (opcode)
            OPC_LUI: begin
                legal         = 1'b1;
                writes_rd     = 1'b1;
                ctrl.op_a_sel = OPA_ZERO;
                ctrl.op_b_imm = 1'b1;
            end
            OPC_AUIPC: begin
                legal         = 1'b1;
                writes_rd     = 1'b1;
                ctrl.op_a_sel = OPA_PC;
                ctrl.op_b_imm = 1'b1;
            end
            OPC_JAL: begin
                legal         = 1'b1;
                writes_rd     = 1'b1;
                ctrl.op_a_sel = OPA_PC;
                ctrl.op_b_imm = 1'b1;
                ctrl.br_type  = BR_JAL;
                ctrl.wb_sel   = WB_PC4;
            end
            OPC_JALR: begin
                legal         = (funct3 == 3'b000);
                writes_rd     = 1'b1;
                reads_rs1     = 1'b1;
                ctrl.op_b_imm = 1'b1;
                ctrl.br_type  = BR_JALR;
                ctrl.wb_sel   = WB_PC4;
            end
            OPC_BRANCH: begin
                // ALU forms the target pc+imm; the comparator reads rs1/rs2.
                legal         = 1'b1;
                reads_rs1     = 1'b1;
                reads_rs2     = 1'b1;
                ctrl.op_a_sel = OPA_PC;
                ctrl.op_b_imm = 1'b1;
                case (funct3)
                    3'b000:  ctrl.br_type = BR_BEQ;
                    3'b001:  ctrl.br_type = BR_BNE;
                    3'b100:  ctrl.br_type = BR_BLT;
                    3'b101:  ctrl.br_type = BR_BGE;
                    3'b110: begin ctrl.br_type = BR_BLT; ctrl.br_unsigned = 1'b1; end
                    3'b111: begin ctrl.br_type = BR_BGE; ctrl.br_unsigned = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal         = 1'b1;
                writes_rd     = 1'b1;
                reads_rs1     = 1'b1;
                ctrl.op_b_imm = 1'b1;
                ctrl.mem_rden = 1'b1;
                ctrl.wb_sel   = WB_MEM;
                case (funct3)
                    3'b000:  ctrl.mem_size = MEM_B;
                    3'b001:  ctrl.mem_size = MEM_H;
                    3'b010:  ctrl.mem_size = MEM_W;
                    3'b100: begin ctrl.mem_size = MEM_B; ctrl.mem_unsigned = 1'b1; end
                    3'b101: begin ctrl.mem_size = MEM_H; ctrl.mem_unsigned = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                legal         = 1'b1;
                reads_rs1     = 1'b1;
                reads_rs2     = 1'b1;
                ctrl.op_b_imm = 1'b1;
                ctrl.mem_wren = 1'b1;
                case (funct3)
                    3'b000:  ctrl.mem_size = MEM_B;
                    3'b001:  ctrl.mem_size = MEM_H;
                    3'b010:  ctrl.mem_size = MEM_W;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                writes_rd     = 1'b1;
                reads_rs1     = 1'b1;
                ctrl.op_b_imm = 1'b1;
                // Shift immediates constrain funct7; bit 30 picks SRAI.
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                alu_op = ALU_OP_W'(base_alu_op(funct3, (funct3 == 3'b101) && funct7[5]));
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal  = 1'b1;
                    alu_op = ALU_OP_W'(base_alu_op(funct3, 1'b0));
                end else if (funct7 == 7'b0100000) begin
                    legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
                    alu_op = ALU_OP_W'(base_alu_op(funct3, 1'b1));
                end else if ((funct7 == 7'b0000001) && (M_EXT != 0)) begin
                    legal  = 1'b1;
                    alu_op = ALU_OP_W'(ALU_MUL) + ALU_OP_W'(funct3);
                end
            end
            // FENCE is a no-op in this in-order pipeline: legal, nothing enabled.
            OPC_MISC_MEM: legal = (funct3 == 3'b000);
            default: legal = 1'b0;
        endcase

        if (legal) begin
            ctrl.alu_op   = CTRL_ALU_OP_W'(alu_op);
            // x0 is never a real destination or hazard source.
            ctrl.rd_wren  = writes_rd && (rd != 5'd0);
            ctrl.uses_rs1 = reads_rs1 && (rs1 != 5'd0);
            ctrl.uses_rs2 = reads_rs2 && (rs2 != 5'd0);
        end else begin
            ctrl = BUBBLE;
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        ctrl.illegal = ~legal;
`else
        ctrl.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered ID-stage decoder with a DEPTH-entry bundle queue.
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid/in_ready         fetch-side handshake; in_instr (32), in_pc (PC_W)
//   flush                     empties the queue next cycle; a same-cycle push is dropped
//   out_valid/out_ready       downstream handshake; out_ctrl, out_pc, out_instr at head
//   illegal_cnt (16)          saturating count of stored illegal instructions
// Head outputs are forced to zero while the queue is empty. in_ready depends only
// on the occupancy count, never on out_ready.
// Build option CTRL_ILLEGAL_TRAP_EN: enables ctrl_t.illegal and illegal_cnt
// (cleared only by rst); when undefined illegal_cnt is tied to 0.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int DEPTH    = 2,
    parameter int M_EXT    = 0,
    parameter int ALU_OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_t           out_ctrl,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [15:0]     illegal_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_mem  [DEPTH];
    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;

    ctrl_decode_core #(
        .M_EXT    (M_EXT),
        .ALU_OP_W (ALU_OP_W)
    ) u_core (
        .instr (in_instr),
        .ctrl  (dec_ctrl)
    );

    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // A pop during flush is simply consumed by the clear.
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Storage needs no reset: nothing is visible until count says it is valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                ctrl_mem[gi]  <= dec_ctrl;
                pc_mem[gi]    <= in_pc;
                instr_mem[gi] <= in_instr;
            end
        end
    end

    assign out_ctrl  = out_valid ? ctrl_mem[rd_ptr_reg]  : BUBBLE;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : '0;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic [15:0] illegal_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_reg <= '0;
        end else if (push && dec_ctrl.illegal && (illegal_cnt_reg != 16'hFFFF)) begin
            illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
        end
    end

    assign illegal_cnt = illegal_cnt_reg;
`else
    assign illegal_cnt = 16'd0;
`endif

endmodule
